// File: rtl/rd_check_scheduler.sv
// Read-phase scheduler: splits a byte-range test request into Avalon-MM read bursts,
// hands one check descriptor per accepted burst to the compare block and gathers results.
// Optional build macro RD_CHECK_TIMEOUT_EN adds a completion watchdog and timeout_o.
module rd_check_scheduler #(
   parameter int AMM_DATA_W      = 128,
   parameter int ADDR_W          = 32,
   parameter int AMM_BURST_W     = 11,
   parameter int MAX_OUTSTANDING = 4,
`ifdef RD_CHECK_TIMEOUT_EN
   parameter int TIMEOUT_CYCLES  = 1024,
`endif
   localparam int BYTE_PER_WORD  = AMM_DATA_W / 8,
   localparam int BYTE_ADDR_W    = $clog2(BYTE_PER_WORD),
   localparam int AMM_ADDR_W     = ADDR_W - BYTE_ADDR_W
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [ADDR_W-1:0]      start_addr_i,
   input  logic [ADDR_W-1:0]      length_i,
   input  logic [AMM_BURST_W-1:0] max_burst_i,
   input  logic [7:0]             data_ptrn_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   error_o,
   output logic [AMM_ADDR_W-1:0]  error_address_o,
`ifdef RD_CHECK_TIMEOUT_EN
   output logic                   timeout_o,
`endif
   output logic                   amm_read_o,
   output logic [AMM_ADDR_W-1:0]  amm_address_o,
   output logic [AMM_BURST_W-1:0] amm_burstcount_o,
   input  logic                   amm_waitrequest_i,
   output logic                   valid_cmp_en_o,
   output logic [BYTE_ADDR_W-1:0] start_offset_o,
   output logic [BYTE_ADDR_W-1:0] end_offset_o,
   output logic [AMM_ADDR_W-1:0]  address_o,
   output logic [AMM_BURST_W-1:0] burst_count_o,
   output logic [7:0]             data_ptrn_o,
   input  logic                   check_valid_i,
   input  logic                   check_result_i,
   input  logic [AMM_ADDR_W-1:0]  error_address_i
);

   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int WL_W  = AMM_ADDR_W + 1;
   localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t                 state_reg, state_next;
   logic [ADDR_W-1:0]      start_addr_reg, length_reg;
   logic [AMM_BURST_W-1:0] max_burst_reg;
   logic [7:0]             ptrn_reg;
   logic [BYTE_ADDR_W-1:0] last_off_reg;
   logic [WL_W-1:0]        words_left_reg;
   logic [AMM_ADDR_W-1:0]  cur_addr_reg;
   logic                   first_burst_reg;
   logic [OUT_W-1:0]       outstanding_reg;
   logic                   error_reg;
   logic [AMM_ADDR_W-1:0]  error_addr_reg;

   logic [ADDR_W-1:0]      last_byte;
   logic [AMM_ADDR_W-1:0]  first_word, last_word, word_span;
   logic [AMM_BURST_W-1:0] burst_len;
   logic                   final_burst, present, accept, start_accept;
   logic                   check_dec, check_fail;
   logic                   timeout_hit;
   logic [AMM_ADDR_W-1:0]  oldest_addr;

   // Last byte wraps modulo 2^ADDR_W, so the word span is taken modulo the word space.
   assign last_byte    = start_addr_reg + length_reg - ADDR_W'(1);
   assign first_word   = start_addr_reg[ADDR_W-1:BYTE_ADDR_W];
   assign last_word    = last_byte[ADDR_W-1:BYTE_ADDR_W];
   assign word_span    = last_word - first_word;

   always_comb begin
      burst_len = max_burst_reg;
      if (words_left_reg < WL_W'(max_burst_reg))
         burst_len = words_left_reg[AMM_BURST_W-1:0];
   end

   assign final_burst  = (words_left_reg == WL_W'(burst_len));
   assign present      = (state_reg == S_ISSUE) && (outstanding_reg < OUT_MAX) && !error_reg;
   assign accept       = present && !amm_waitrequest_i;
   assign start_accept = (state_reg == S_IDLE) && start_i;
   assign check_dec    = check_valid_i && (outstanding_reg != '0);
   assign check_fail   = check_dec && !check_result_i;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start_i) state_next = (length_i == '0) ? S_DONE : S_CALC;
         S_CALC:  state_next = S_ISSUE;
         S_ISSUE: if (error_reg || (accept && final_burst)) state_next = S_DRAIN;
         S_DRAIN: if (outstanding_reg == '0) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (timeout_hit) state_next = S_DONE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg       <= S_IDLE;
         start_addr_reg  <= '0;
         length_reg      <= '0;
         max_burst_reg   <= '0;
         ptrn_reg        <= '0;
         last_off_reg    <= '0;
         words_left_reg  <= '0;
         cur_addr_reg    <= '0;
         first_burst_reg <= 1'b0;
         outstanding_reg <= '0;
         error_reg       <= 1'b0;
         error_addr_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (start_accept) begin
            start_addr_reg <= start_addr_i;
            length_reg     <= length_i;
            max_burst_reg  <= (max_burst_i == '0) ? AMM_BURST_W'(1) : max_burst_i;
            ptrn_reg       <= data_ptrn_i;
            error_reg      <= 1'b0;
            error_addr_reg <= '0;
         end
         if (state_reg == S_CALC) begin
            cur_addr_reg    <= first_word;
            words_left_reg  <= {1'b0, word_span} + WL_W'(1);
            last_off_reg    <= last_byte[BYTE_ADDR_W-1:0];
            first_burst_reg <= 1'b1;
         end
         if (accept) begin
            cur_addr_reg    <= cur_addr_reg + AMM_ADDR_W'(burst_len);
            words_left_reg  <= words_left_reg - WL_W'(burst_len);
            first_burst_reg <= 1'b0;
         end
         if (timeout_hit)
            outstanding_reg <= '0;
         else if (accept && !check_dec)
            outstanding_reg <= outstanding_reg + OUT_W'(1);
         else if (!accept && check_dec)
            outstanding_reg <= outstanding_reg - OUT_W'(1);
         // Only the first failure of a test is recorded.
         if (check_fail && !error_reg) begin
            error_reg      <= 1'b1;
            error_addr_reg <= error_address_i;
         end else if (timeout_hit && !error_reg) begin
            error_reg      <= 1'b1;
            error_addr_reg <= oldest_addr;
         end
      end
   end

`ifdef RD_CHECK_TIMEOUT_EN
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   logic [AMM_ADDR_W-1:0] burst_addr_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
   logic [TO_W-1:0]       to_cnt_reg;
   logic                  timeout_reg;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Burst addresses in issue order; checks complete in the same order.
   always_ff @(posedge clk_i) begin
      if (accept) burst_addr_mem[wr_ptr_reg] <= cur_addr_reg;
   end

   assign oldest_addr = burst_addr_mem[rd_ptr_reg];
   assign timeout_hit = (outstanding_reg != '0) && !check_valid_i &&
                        (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
   assign timeout_o   = timeout_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         to_cnt_reg  <= '0;
         timeout_reg <= 1'b0;
      end else begin
         if (start_accept)     timeout_reg <= 1'b0;
         else if (timeout_hit) timeout_reg <= 1'b1;
         if (start_accept || timeout_hit) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (accept)    wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (check_dec) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         if (check_valid_i || (outstanding_reg == '0) || timeout_hit)
            to_cnt_reg <= '0;
         else
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign oldest_addr = '0;
`endif

   assign busy_o           = (state_reg == S_CALC) || (state_reg == S_ISSUE) || (state_reg == S_DRAIN);
   assign done_o           = (state_reg == S_DONE);
   assign error_o          = error_reg;
   assign error_address_o  = error_addr_reg;
   assign amm_read_o       = present;
   assign amm_address_o    = present ? cur_addr_reg : '0;
   assign amm_burstcount_o = present ? burst_len : '0;
   assign valid_cmp_en_o   = accept;
   assign start_offset_o   = (accept && first_burst_reg) ? start_addr_reg[BYTE_ADDR_W-1:0] : '0;
   assign end_offset_o     = accept ? (final_burst ? last_off_reg : '1) : '0;
   assign address_o        = accept ? cur_addr_reg : '0;
   assign burst_count_o    = accept ? burst_len : '0;
   assign data_ptrn_o      = accept ? ptrn_reg : '0;

endmodule
